instr_fetch_seq: RTL and testbench

//  Instruction fetch/sequencer directly upstream of processor: owns the program memory and PC, and

---
 rtl/ifetch_pkg.sv | 27 ++
 rtl/ifetch_imem.sv | 36 +++
 rtl/instr_fetch_seq.sv | 137 +++++++++++++
 tb/tb_instr_fetch_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants, state encoding and opcode helpers for the fetch sequencer.
// Optional single-step gating is enabled by defining IFETCH_STEP_EN.
package ifetch_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int VEC_BIT = 27;

  localparam logic [3:0]  OP_HALT   = 4'hF;
  localparam logic [31:0] INSTR_NOP = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_HALTED
  } state_e;

  function automatic logic is_halt(input logic [31:0] w);
    return w[OPC_MSB:OPC_LSB] == OP_HALT;
  endfunction

  function automatic logic is_vec(input logic [31:0] w);
    return w[VEC_BIT];
  endfunction

endpackage

// File: rtl/ifetch_imem.sv
// Program memory: one write port, synchronous write-first read into a reset IR.
// Ports: clk/rst, we/waddr/wdata write, re/raddr read, rdata = registered word.
module ifetch_imem
  import ifetch_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the instruction register, so it resets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_q <= INSTR_NOP;
    else if (re)
      rdata_q <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/sequencer: owns PC and IMEM, issues scalars 1 cycle, vectors VEC_BEATS.
// Ports: clk, reset, start/start_addr, abort, prog_*, instruction/valid/beat/pc/status.
// Defining IFETCH_STEP_EN adds a step input that gates FILL/ISSUE advances.
module instr_fetch_seq
  import ifetch_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int IMEM_DEPTH = 256,
  parameter int VEC_BEATS  = 4
) (
  input  logic            clk,
  input  logic            reset,
`ifdef IFETCH_STEP_EN
  input  logic            step,
`endif
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            abort,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [31:0]     prog_data,
  output logic [31:0]     instruction,
  output logic            instr_valid,
  output logic [1:0]      beat,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            prog_err
);

  localparam logic [PC_W-1:0] PC_INC    = PC_W'(1);
  localparam logic [1:0]      BEAT_LAST = 2'(VEC_BEATS - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      beat_q, beat_d;
  logic            halted_q, halted_d;
  logic            prog_err_q;
  logic            rd_en, wr_en, adv;
  logic            is_busy, issuing;
  logic [31:0]     ir;

`ifdef IFETCH_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign is_busy = (state_q == S_FILL) || (state_q == S_ISSUE);
  assign wr_en   = prog_we && !is_busy;

  ifetch_imem #(
    .AW   (PC_W),
    .DEPTH(IMEM_DEPTH)
  ) u_imem (
    .clk  (clk),
    .rst  (reset),
    .we   (wr_en),
    .waddr(prog_addr),
    .wdata(prog_data),
    .re   (rd_en),
    .raddr(pc_q),
    .rdata(ir)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    beat_d   = beat_q;
    halted_d = halted_q;
    rd_en    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d  = S_FILL;
          pc_d     = start_addr;
          halted_d = 1'b0;
        end
      end
      S_FILL: begin
        if (adv) begin
          rd_en   = 1'b1;
          state_d = S_ISSUE;
          beat_d  = 2'd0;
        end
      end
      S_ISSUE: begin
        // HALT retires without waiting for a step.
        if (is_halt(ir)) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else if (adv) begin
          if (is_vec(ir) && beat_q != BEAT_LAST) begin
            beat_d = beat_q + 2'd1;
          end else begin
            beat_d  = 2'd0;
            pc_d    = pc_q + PC_INC;
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      pc_d     = pc_q;
      beat_d   = 2'd0;
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      beat_q     <= 2'd0;
      halted_q   <= 1'b0;
      prog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      beat_q     <= beat_d;
      halted_q   <= halted_d;
      prog_err_q <= prog_we && is_busy;
    end
  end

  assign issuing     = (state_q == S_ISSUE) && !is_halt(ir);
  assign instr_valid = issuing;
  assign instruction = issuing ? ir : INSTR_NOP;
  assign beat        = beat_q;
  assign pc          = pc_q;
  assign busy        = is_busy;
  assign halted      = halted_q;
  assign prog_err    = prog_err_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed cases plus random programs
// compared against a cycle trace expanded from the program image.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  start_addr = 8'd0;
  logic [7:0]  prog_addr = 8'd0;
  logic [31:0] prog_data = 32'd0;
`ifdef IFETCH_STEP_EN
  logic        step = 1'b1;
`endif

  logic [31:0] instruction;
  logic        instr_valid;
  logic [1:0]  beat;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        prog_err;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] mdl_mem [256];

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [1:0]  bt;
    logic [7:0]  pc;
    logic        bz;
    logic        hl;
  } cyc_t;

  cyc_t exp_q[$];

  instr_fetch_seq dut (
    .clk        (clk),
    .reset      (reset),
`ifdef IFETCH_STEP_EN
    .step       (step),
`endif
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .beat       (beat),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .prog_err   (prog_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(5) == 0) w[31:28] = 4'hF;
    else if (w[31:28] == 4'hF) w[31:28] = 4'h0;
    return w;
  endfunction

  task automatic prog(input logic [7:0] a, input logic [31:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    mdl_mem[a] = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic [7:0] p);
    check({tag, ".valid"}, instr_valid, 1'b0);
    check({tag, ".instr"}, instruction, 32'h0);
    check({tag, ".beat"}, beat, 2'd0);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".halted"}, halted, 1'b0);
    check({tag, ".pc"}, p, pc);
  endtask

  task automatic do_abort(input logic [7:0] p);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort", p);
  endtask

  // Expand the program image into the per-cycle outputs a run must produce:
  // one fetch cycle per word, then 1 (scalar) or 4 (vector) issue cycles.
  task automatic build_trace(input logic [7:0] sa, input int cap);
    logic [7:0]  a;
    logic [31:0] w;
    int          nb;
    exp_q.delete();
    a = sa;
    while (exp_q.size() < cap) begin
      w = mdl_mem[a];
      exp_q.push_back('{1'b0, 32'h0, 2'd0, a, 1'b1, 1'b0});
      if (w[31:28] == 4'hF) begin
        exp_q.push_back('{1'b0, 32'h0, 2'd0, a, 1'b1, 1'b0});
        exp_q.push_back('{1'b0, 32'h0, 2'd0, a, 1'b0, 1'b1});
        return;
      end
      nb = w[27] ? 4 : 1;
      for (int b = 0; b < nb; b++)
        exp_q.push_back('{1'b1, w, 2'(b), a, 1'b1, 1'b0});
      a = a + 8'd1;
    end
  endtask

  task automatic run(input logic [7:0] sa, input int cap, input bit noise,
                     output bit did_halt);
    cyc_t e;
    logic err_exp;
    int   n;
    err_exp = 1'b0;
    start = 1'b1;
    start_addr = sa;
    if (noise && $urandom_range(1) == 1) begin
      prog_we = 1'b1;
      prog_addr = sa;
      prog_data = rand_word();
      mdl_mem[sa] = prog_data;
    end
    build_trace(sa, cap);
    tick();
    start = 1'b0;
    prog_we = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      check("valid", instr_valid, e.v);
      check("instr", instruction, e.ins);
      check("beat", beat, e.bt);
      check("pc", pc, e.pc);
      check("busy", busy, e.bz);
      check("halted", halted, e.hl);
      check("prog_err", prog_err, err_exp);
      err_exp = 1'b0;
      if (i < n - 1) begin
        if (noise && e.bz) begin
          if ($urandom_range(3) == 0) begin
            start = 1'b1;
            start_addr = 8'($urandom);
          end
          if ($urandom_range(3) == 0) begin
            prog_we = 1'b1;
            prog_addr = 8'($urandom);
            prog_data = $urandom;
            err_exp = 1'b1;
          end
        end
        tick();
        start = 1'b0;
        prog_we = 1'b0;
      end
    end
    did_halt = exp_q[n-1].hl;
  endtask

  initial begin
    bit h;
    logic [7:0] sa;

    repeat (2) tick();
    check("rst.instr", instruction, 32'h0);
    check("rst.valid", instr_valid, 1'b0);
    check("rst.beat", beat, 2'd0);
    check("rst.pc", pc, 8'd0);
    check("rst.busy", busy, 1'b0);
    check("rst.halted", halted, 1'b0);
    check("rst.prog_err", prog_err, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) prog(8'(i), rand_word());

    // Two scalars then HALT.
    prog(8'd0, 32'h1234_5678);
    prog(8'd1, 32'h2000_00AB);
    prog(8'd2, 32'hF000_0000);
    prog(8'd5, 32'h0800_0042);
    prog(8'd6, 32'hF000_0001);
    prog(8'd9, 32'h3000_0999);
    prog(8'd10, 32'hF000_0002);
    run(8'd0, 40, 1'b0, h);
    repeat (3) tick();
    check("t1.halted_hold", halted, 1'b1);
    check("t1.instr_nop", instruction, 32'h0);

    // Vector word from HALTED.
    run(8'd5, 40, 1'b0, h);

    // Write while busy is dropped and flagged.
    start = 1'b1;
    start_addr = 8'd0;
    tick();
    start = 1'b0;
    prog_we = 1'b1;
    prog_addr = 8'd9;
    prog_data = 32'h3DEA_DBEE;
    tick();
    prog_we = 1'b0;
    check("t3.prog_err", prog_err, 1'b1);
    tick();
    check("t3.prog_err_pulse", prog_err, 1'b0);
    do_abort(pc);
    run(8'd9, 40, 1'b0, h);

    // Abort on beat 2 of a vector.
    start = 1'b1;
    start_addr = 8'd5;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t4.beat", beat, 2'd2);
    check("t4.instr", instruction, 32'h0800_0042);
    do_abort(8'd5);

    // PC wrap.
    prog(8'd255, 32'h3000_0001);
    prog(8'd0, 32'hF000_0000);
    run(8'd255, 40, 1'b0, h);

    // Asynchronous reset in the middle of a vector issue.
    start = 1'b1;
    start_addr = 8'd5;
    tick();
    start = 1'b0;
    tick();
    check("t6.pre_valid", instr_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t6.rst_instr", instruction, 32'h0);
    check("t6.rst_valid", instr_valid, 1'b0);
    check("t6.rst_beat", beat, 2'd0);
    check("t6.rst_pc", pc, 8'd0);
    check("t6.rst_busy", busy, 1'b0);
    check("t6.rst_halted", halted, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    run(8'd5, 40, 1'b0, h);
    run(8'd255, 40, 1'b0, h);

`ifdef IFETCH_STEP_EN
    start = 1'b1;
    start_addr = 8'd5;
    tick();
    start = 1'b0;
    tick();
    step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("step.valid", instr_valid, 1'b1);
      check("step.instr", instruction, 32'h0800_0042);
      check("step.beat", beat, 2'd0);
      check("step.pc", pc, 8'd5);
      tick();
    end
    step = 1'b1;
    tick();
    check("step.beat1", beat, 2'd1);
    do_abort(8'd5);
`endif

    for (int it = 0; it < 40; it++) begin
      for (int k = $urandom_range(6); k > 0; k--)
        prog(8'($urandom), rand_word());
      sa = 8'($urandom);
      run(sa, 50, 1'b1, h);
      if (!h) do_abort(pc);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
